// File: rtl/ro_sweep_ctrl.sv
// ro_sweep_ctrl: ring-oscillator tap sweep sequencer.
// Steps the ring clock-select code from lo to hi. For each tap it waits a settle
// period, then counts synchronised rising edges of osc_in over a fixed window,
// and hands each count out on a valid/ready result port.
// Optional min/max tracking is compiled in when RO_SWEEP_MINMAX_EN is defined.
module ro_sweep_ctrl #(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [3:0]       tap_first,
    input  logic [3:0]       tap_last,
    input  logic             osc_in,
    output logic [3:0]       clksel_out,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_tap,
    output logic [CNT_W-1:0] res_count,
    output logic             res_overflow,
`ifdef RO_SWEEP_MINMAX_EN
    output logic [3:0]       min_tap,
    output logic [3:0]       max_tap,
    output logic [CNT_W-1:0] min_count,
    output logic [CNT_W-1:0] max_count,
`endif
    output logic             done
);

    localparam int MAXC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic                   prev_reg, prev_next;
    logic [3:0]             lo_reg, lo_next, hi_reg, hi_next, cur_reg, cur_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic [CNT_W-1:0]       count_reg, count_next, count_upd;
    logic                   ovf_reg, ovf_next, ovf_upd;
    logic                   res_valid_reg, res_valid_next;
    logic [3:0]             res_tap_reg, res_tap_next;
    logic [CNT_W-1:0]       res_count_reg, res_count_next;
    logic                   res_ovf_reg, res_ovf_next;
    logic                   done_reg, done_next;
    logic [3:0]             clksel_reg, clksel_next;
    logic [3:0]             lo_c, hi_c;
    logic                   edge_det;
`ifdef RO_SWEEP_MINMAX_EN
    logic [3:0]             min_tap_reg, min_tap_next, max_tap_reg, max_tap_next;
    logic [CNT_W-1:0]       min_count_reg, min_count_next, max_count_reg, max_count_next;
    logic                   mm_first_reg, mm_first_next;
`endif

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Synchroniser shift chain bringing the asynchronous oscillator into clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], osc_in};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            prev_reg      <= 1'b0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            cur_reg       <= '0;
            timer_reg     <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
            res_tap_reg   <= '0;
            res_count_reg <= '0;
            res_ovf_reg   <= 1'b0;
            done_reg      <= 1'b0;
            clksel_reg    <= '0;
`ifdef RO_SWEEP_MINMAX_EN
            min_tap_reg   <= '0;
            max_tap_reg   <= '0;
            min_count_reg <= '0;
            max_count_reg <= '0;
            mm_first_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            lo_reg        <= lo_next;
            hi_reg        <= hi_next;
            cur_reg       <= cur_next;
            timer_reg     <= timer_next;
            count_reg     <= count_next;
            ovf_reg       <= ovf_next;
            res_valid_reg <= res_valid_next;
            res_tap_reg   <= res_tap_next;
            res_count_reg <= res_count_next;
            res_ovf_reg   <= res_ovf_next;
            done_reg      <= done_next;
            clksel_reg    <= clksel_next;
`ifdef RO_SWEEP_MINMAX_EN
            min_tap_reg   <= min_tap_next;
            max_tap_reg   <= max_tap_next;
            min_count_reg <= min_count_next;
            max_count_reg <= max_count_next;
            mm_first_reg  <= mm_first_next;
`endif
        end
    end

    // Next-state, counting and result logic; abort overrides every transition.
    always_comb begin
        state_next     = state_reg;
        prev_next      = prev_reg;
        lo_next        = lo_reg;
        hi_next        = hi_reg;
        cur_next       = cur_reg;
        timer_next     = timer_reg;
        count_next     = count_reg;
        ovf_next       = ovf_reg;
        res_valid_next = res_valid_reg;
        res_tap_next   = res_tap_reg;
        res_count_next = res_count_reg;
        res_ovf_next   = res_ovf_reg;
        done_next      = 1'b0;
`ifdef RO_SWEEP_MINMAX_EN
        min_tap_next   = min_tap_reg;
        max_tap_next   = max_tap_reg;
        min_count_next = min_count_reg;
        max_count_next = max_count_reg;
        mm_first_next  = mm_first_reg;
`endif

        // Codes 0 and 1 are plain clk, so the sweep never goes below 2.
        lo_c = (tap_first < 4'd2) ? 4'd2 : tap_first;
        hi_c = (tap_last < lo_c) ? lo_c : tap_last;

        // Saturating edge count; overflow marks an edge lost to saturation.
        edge_det  = sync_out & ~prev_reg;
        count_upd = count_reg;
        ovf_upd   = ovf_reg;
        if (edge_det) begin
            if (count_reg == CNT_MAX) begin
                ovf_upd = 1'b1;
            end else begin
                count_upd = count_reg + CNT_W'(1);
            end
        end

        if (abort) begin
            state_next     = S_IDLE;
            res_valid_next = 1'b0;
            timer_next     = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        lo_next    = lo_c;
                        hi_next    = hi_c;
                        cur_next   = lo_c;
                        timer_next = '0;
                        state_next = S_SETTLE;
`ifdef RO_SWEEP_MINMAX_EN
                        min_tap_next   = '0;
                        max_tap_next   = '0;
                        min_count_next = '0;
                        max_count_next = '0;
                        mm_first_next  = 1'b1;
`endif
                    end
                end
                S_SETTLE: begin
                    // Track the oscillator so the window does not open on a false edge.
                    prev_next  = sync_out;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    if (timer_reg == SETTLE_LAST) begin
                        timer_next = '0;
                        state_next = S_MEASURE;
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                S_MEASURE: begin
                    prev_next  = sync_out;
                    count_next = count_upd;
                    ovf_next   = ovf_upd;
                    if (timer_reg == GATE_LAST) begin
                        timer_next     = '0;
                        res_tap_next   = cur_reg;
                        res_count_next = count_upd;
                        res_ovf_next   = ovf_upd;
                        res_valid_next = 1'b1;
                        state_next     = S_REPORT;
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                S_REPORT: begin
                    if (res_valid_reg && res_ready) begin
                        res_valid_next = 1'b0;
`ifdef RO_SWEEP_MINMAX_EN
                        if (mm_first_reg || (res_count_reg < min_count_reg)) begin
                            min_count_next = res_count_reg;
                            min_tap_next   = res_tap_reg;
                        end
                        if (mm_first_reg || (res_count_reg > max_count_reg)) begin
                            max_count_next = res_count_reg;
                            max_tap_next   = res_tap_reg;
                        end
                        mm_first_next = 1'b0;
`endif
                        if (cur_reg < hi_reg) begin
                            cur_next   = cur_reg + 4'd1;
                            state_next = S_SETTLE;
                        end else if (continuous) begin
                            cur_next   = lo_reg;
                            state_next = S_SETTLE;
                        end else begin
                            done_next  = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        // The ring runs only while a sweep is active.
        clksel_next = (state_next == S_IDLE) ? 4'd0 : cur_next;
    end

    assign busy         = (state_reg != S_IDLE);
    assign clksel_out   = clksel_reg;
    assign res_valid    = res_valid_reg;
    assign res_tap      = res_tap_reg;
    assign res_count    = res_count_reg;
    assign res_overflow = res_ovf_reg;
    assign done         = done_reg;
`ifdef RO_SWEEP_MINMAX_EN
    assign min_tap      = min_tap_reg;
    assign max_tap      = max_tap_reg;
    assign min_count    = min_count_reg;
    assign max_count    = max_count_reg;
`endif

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Directed testbench for ro_sweep_ctrl (GATE=64, SETTLE=4, CNT_W=4).
module tb_ro_sweep_ctrl;
    localparam int G  = 64;
    localparam int S  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic          res_ready = 1'b0, osc_in = 1'b0;
    logic [3:0]    tap_first = 4'd0, tap_last = 4'd0;
    logic [3:0]    clksel_out, res_tap;
    logic          busy, res_valid, res_overflow, done;
    logic [CW-1:0] res_count;
`ifdef RO_SWEEP_MINMAX_EN
    logic [3:0]    min_tap, max_tap;
    logic [CW-1:0] min_count, max_count;
`endif

    ro_sweep_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .abort(abort),
        .tap_first(tap_first), .tap_last(tap_last), .osc_in(osc_in),
        .clksel_out(clksel_out), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_tap(res_tap), .res_count(res_count), .res_overflow(res_overflow),
`ifdef RO_SWEEP_MINMAX_EN
        .min_tap(min_tap), .max_tap(max_tap), .min_count(min_count), .max_count(max_count),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Oscillator model: toggles every osc_half clk cycles, held low when osc_half is 0.
    int osc_half = 0;
    int osc_cnt  = 0;
    always @(negedge clk) begin
        if (osc_half == 0) begin
            osc_in  = 1'b0;
            osc_cnt = 0;
        end else begin
            osc_cnt = osc_cnt + 1;
            if (osc_cnt >= osc_half) begin
                osc_cnt = 0;
                osc_in  = ~osc_in;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [3:0]    q_tap[$];
    logic [CW-1:0] q_cnt[$];
    logic          q_ovf[$];
    logic [3:0]    sel_q[$];
    int            vrise_q[$];
    logic [3:0]    last_sel;
    logic          last_valid;
    int            done_cnt, done_cyc, hs_cyc, bad_sel;

    task automatic clear_log();
        q_tap.delete(); q_cnt.delete(); q_ovf.delete(); sel_q.delete(); vrise_q.delete();
        last_sel = clksel_out; last_valid = res_valid;
        done_cnt = 0; done_cyc = -1; hs_cyc = -1; bad_sel = 0;
    endtask

    // Advance one clock; log handshakes, done pulses, clksel changes and valid rises.
    task automatic step();
        if (res_valid && res_ready) begin
            q_tap.push_back(res_tap); q_cnt.push_back(res_count); q_ovf.push_back(res_overflow);
            hs_cyc = cyc;
            $display("[TB] cycle %0d result tap=%0d count=%0d ovf=%0d", cyc, res_tap, res_count, res_overflow);
        end
        @(posedge clk); #1;
        cyc = cyc + 1;
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (clksel_out !== last_sel) begin sel_q.push_back(clksel_out); last_sel = clksel_out; end
        if (busy && clksel_out < 4'd2) bad_sel = bad_sel + 1;
        if (res_valid && !last_valid) vrise_q.push_back(cyc);
        last_valid = res_valid;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt > 0) begin timed_out = 1'b0; break; end
        end
    endtask

    function automatic logic [3:0] tap_at(input int i);
        return (q_tap.size() > i) ? q_tap[i] : 4'hx;
    endfunction

    function automatic int cnt_at(input int i);
        return (q_cnt.size() > i) ? int'(q_cnt[i]) : -1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        tests++;
        if ({clksel_out, busy, res_valid, res_tap, res_count, res_overflow, done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got sel=%0d busy=%0d valid=%0d tap=%0d cnt=%0d ovf=%0d done=%0d expected all 0",
                     clksel_out, busy, res_valid, res_tap, res_count, res_overflow, done);
        end
        reset_n = 1'b1;
        step(); step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: got busy=%0d expected 0", busy); end
    endtask

    task automatic test_sweep_basics();
        bit to;
        int start_cyc, lat;
        logic [3:0] exp_sel[4];
        tap_first = 4'd2; tap_last = 4'd4; res_ready = 1'b1; continuous = 1'b0; osc_half = 4;
        step(); step();
        clear_log();
        start_cyc = cyc;
        pulse_start();
        run_until_done(2000, to);
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (to) begin fails++; $display("FAIL basics_timeout: got no done expected done"); end
        tests++;
        if (q_tap.size() != 3) begin fails++; $display("FAIL basics_nresults: got %0d expected 3", q_tap.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (tap_at(i) !== 4'(i + 2)) begin
                fails++; $display("FAIL basics_tap%0d: got %0d expected %0d", i, tap_at(i), i + 2);
            end
            tests++;
            if (cnt_at(i) < 7 || cnt_at(i) > 9) begin
                fails++; $display("FAIL basics_count%0d: got %0d expected 7..9", i, cnt_at(i));
            end
        end
        exp_sel = '{4'd2, 4'd3, 4'd4, 4'd0};
        tests++;
        if (sel_q.size() != 4) begin
            fails++; $display("FAIL basics_sel_len: got %0d changes expected 4", sel_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (sel_q[i] !== exp_sel[i]) begin
                    fails++; $display("FAIL basics_sel%0d: got %0d expected %0d", i, sel_q[i], exp_sel[i]);
                end
            end
        end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL basics_done_count: got %0d expected 1", done_cnt); end
        tests++;
        if (done_cyc != hs_cyc + 1) begin
            fails++; $display("FAIL basics_done_timing: got cycle %0d expected %0d", done_cyc, hs_cyc + 1);
        end
        // Start-to-valid latency; the window allows for whether the start cycle itself is counted.
        lat = (vrise_q.size() > 0) ? vrise_q[0] - start_cyc : -1;
        tests++;
        if (lat < S + G + 1 || lat > S + G + 2) begin
            fails++; $display("FAIL basics_latency: got %0d expected %0d..%0d", lat, S + G + 1, S + G + 2);
        end
        lat = (vrise_q.size() > 1) ? vrise_q[1] - vrise_q[0] : -1;
        tests++;
        if (lat != S + G + 1) begin
            fails++; $display("FAIL basics_tap_period: got %0d expected %0d", lat, S + G + 1);
        end
    endtask

    task automatic test_range_clamp();
        bit to;
        tap_first = 4'd0; tap_last = 4'd1; res_ready = 1'b1;
        clear_log();
        pulse_start();
        run_until_done(500, to);
        step(); step();
        tests++;
        if (to || q_tap.size() != 1) begin
            fails++; $display("FAIL clamp_nresults: got %0d expected 1", q_tap.size());
        end
        tests++;
        if (tap_at(0) !== 4'd2) begin fails++; $display("FAIL clamp_tap: got %0d expected 2", tap_at(0)); end
        tests++;
        if (bad_sel != 0) begin fails++; $display("FAIL clamp_sel_low: got %0d busy cycles with sel<2 expected 0", bad_sel); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        logic [3:0]    t0;
        logic [CW-1:0] c0;
        tap_first = 4'd2; tap_last = 4'd3; res_ready = 1'b0; osc_half = 4;
        clear_log();
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (res_valid) begin to = 1'b0; break; end
        end
        tests++;
        if (to) begin fails++; $display("FAIL bp_valid_timeout: got no res_valid expected res_valid"); end
        t0 = res_tap; c0 = res_count; bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_tap !== t0 || res_count !== c0 || res_valid !== 1'b1 || clksel_out !== 4'd2 || busy !== 1'b1)
                bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        res_ready = 1'b1;
        run_until_done(500, to);
        step();
        tests++;
        if (to || q_tap.size() != 2) begin fails++; $display("FAIL bp_nresults: got %0d expected 2", q_tap.size()); end
        tests++;
        if (tap_at(0) !== 4'd2 || cnt_at(0) != int'(c0)) begin
            fails++; $display("FAIL bp_first: got tap=%0d cnt=%0d expected tap=2 cnt=%0d", tap_at(0), cnt_at(0), c0);
        end
        tests++;
        if (tap_at(1) !== 4'd3 || cnt_at(1) < 7 || cnt_at(1) > 9) begin
            fails++; $display("FAIL bp_second: got tap=%0d cnt=%0d expected tap=3 cnt=7..9", tap_at(1), cnt_at(1));
        end
    endtask

    task automatic test_overflow();
        bit to;
        tap_first = 4'd2; tap_last = 4'd3; res_ready = 1'b0; osc_half = 1;
        clear_log();
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (res_valid) begin to = 1'b0; break; end
        end
        tests++;
        if (to || res_count !== 4'd15 || res_overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_saturate: got cnt=%0d ovf=%0d expected cnt=15 ovf=1", res_count, res_overflow);
        end
        osc_half = 0;
        res_ready = 1'b1;
        run_until_done(500, to);
        step();
        tests++;
        if (to || tap_at(1) !== 4'd3 || cnt_at(1) != 0 || q_ovf.size() < 2 || q_ovf[1] !== 1'b0) begin
            fails++; $display("FAIL ovf_quiet_tap: got tap=%0d cnt=%0d n=%0d expected tap=3 cnt=0 ovf=0",
                              tap_at(1), cnt_at(1), q_tap.size());
        end
`ifdef RO_SWEEP_MINMAX_EN
        tests++;
        if (min_tap !== 4'd3 || min_count !== 4'd0 || max_tap !== 4'd2 || max_count !== 4'd15) begin
            fails++; $display("FAIL minmax: got min=%0d/%0d max=%0d/%0d expected min=3/0 max=2/15",
                              min_tap, min_count, max_tap, max_count);
        end
`endif
    endtask

    task automatic test_abort_restart();
        bit to;
        tap_first = 4'd2; tap_last = 4'd4; res_ready = 1'b1; osc_half = 4;
        clear_log();
        pulse_start();
        for (int i = 0; i < S + 10; i++) step();
        abort = 1'b1; step(); abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || clksel_out !== 4'd0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL abort_idle: got busy=%0d sel=%0d valid=%0d expected 0 0 0", busy, clksel_out, res_valid);
        end
        for (int i = 0; i < G + S + 20; i++) step();
        tests++;
        if (vrise_q.size() != 0 || done_cnt != 0) begin
            fails++; $display("FAIL abort_silent: got %0d valids %0d dones expected 0 0", vrise_q.size(), done_cnt);
        end
        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_vs_start: got busy=%0d expected 0", busy); end
        // a start while busy, with new taps, changes nothing
        tap_first = 4'd2; tap_last = 4'd2;
        clear_log();
        pulse_start();
        step(); step(); step();
        tap_first = 4'd5; tap_last = 4'd6;
        start = 1'b1; step(); start = 1'b0;
        run_until_done(500, to);
        for (int i = 0; i < 10; i++) step();
        tests++;
        if (to || q_tap.size() != 1 || tap_at(0) !== 4'd2 || busy !== 1'b0) begin
            fails++; $display("FAIL start_while_busy: got n=%0d tap=%0d busy=%0d expected n=1 tap=2 busy=0",
                              q_tap.size(), tap_at(0), busy);
        end
        // asynchronous reset in the middle of SETTLE
        tap_first = 4'd5; tap_last = 4'd6;
        clear_log();
        pulse_start();
        step();
        tests++;
        if (clksel_out !== 4'd5 || busy !== 1'b1) begin
            fails++; $display("FAIL settle_entry: got sel=%0d busy=%0d expected 5 1", clksel_out, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({clksel_out, busy, res_valid, res_tap, res_count, res_overflow, done} !== '0) begin
            fails++; $display("FAIL async_reset: got sel=%0d busy=%0d valid=%0d tap=%0d cnt=%0d expected all 0",
                              clksel_out, busy, res_valid, res_tap, res_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(); step();
    endtask

    task automatic test_continuous();
        bit to;
        int n;
        tap_first = 4'd14; tap_last = 4'd15; res_ready = 1'b1; continuous = 1'b1; osc_half = 4;
        clear_log();
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (q_tap.size() >= 4) begin to = 1'b0; break; end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (tap_at(i) !== ((i % 2 == 0) ? 4'd14 : 4'd15)) begin
                fails++; $display("FAIL cont_tap%0d: got %0d expected %0d", i, tap_at(i), (i % 2 == 0) ? 14 : 15);
            end
        end
        tests++;
        if (to || done_cnt != 0) begin fails++; $display("FAIL cont_no_done: got %0d dones expected 0", done_cnt); end
        continuous = 1'b0;
        n = q_tap.size();
        run_until_done(1000, to);
        step();
        tests++;
        if (to || q_tap.size() != n + 2 || tap_at(n) !== 4'd14 || tap_at(n + 1) !== 4'd15 || done_cnt != 1) begin
            fails++; $display("FAIL cont_stop: got %0d extra results last=%0d dones=%0d expected 2 extra last=15 dones=1",
                              q_tap.size() - n, tap_at(q_tap.size() - 1), done_cnt);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_sweep_basics();
        test_range_clamp();
        test_backpressure();
        test_overflow();
        test_abort_restart();
        test_continuous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
